// File: rtl/ula_seq_pkg.sv
// ---------------------------------------------------------------------------
// ula_seq_pkg
//   Shared definitions for the handshaked ALU ula_seq:
//   - opcode encodings (OP_ADD .. OP_SHR), 4 bits wide
//   - FSM state encoding (ST_IDLE / ST_BUSY / ST_HOLD)
//   - flags_t: the registered flag set {c, z, n, v, err}
// ---------------------------------------------------------------------------
package ula_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_EQ  = 4'd6;
    localparam logic [3:0] OP_NEQ = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;
    localparam logic [3:0] OP_SHR = 4'd10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
        logic err;
    } flags_t;

endpackage

// File: rtl/ula_seq_mul.sv
// ---------------------------------------------------------------------------
// ula_seq_mul
//   N-step unsigned shift-add multiplier. One partial-product step per cycle
//   while step=1; the product of the final step is presented combinationally
//   together with done so the caller can register it on that same edge.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load operands a, b (accept edge)
//   step         perform one partial-product step this cycle
//   a, b         N-bit unsigned operands, sampled on start
//   done         this step is the N-th (last) one
//   product      2N-bit {hi, lo} value after the current step
// ---------------------------------------------------------------------------
module ula_seq_mul #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           step,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int CW = $clog2(N);

    logic [N-1:0]  mcand;
    logic [N-1:0]  hi;
    logic [N-1:0]  lo;     // multiplier bits still to consume, product low half fills in from the top
    logic [CW-1:0] count;
    logic [N:0]    sum;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(N+1){1'b0}});
        product = {sum, lo[N-1:1]};
        done    = step && (count == CW'(N-1));
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            count <= '0;
        end else if (start) begin
            mcand <= a;
            hi    <= '0;
            lo    <= b;
            count <= '0;
        end else if (step) begin
            {hi, lo} <= product;
            count    <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ula_seq.sv
// ---------------------------------------------------------------------------
// ula_seq
//   Parametrised valid/ready ALU with full flag set, shifts and an optional
//   multi-cycle shift-add multiply. Operands are captured on the accept edge;
//   results are held in an output register until the consumer takes them.
// Configuration
//   ULA_SEQ_MUL_EN  defined: opcode 8 is an N-cycle unsigned multiply.
//                   undefined: no multiplier/BUSY state; opcode 8 is invalid
//                   and s_hi is tied to 0.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE)
//   a, b, opcode         N-bit operands, 4-bit operation select
//   out_valid/out_ready  result handshake (result held while out_ready=0)
//   s, s_hi              result, MUL high half (0 for other ops)
//   c, z, n, v, err      carry/borrow, zero, negative, overflow, bad opcode
// ---------------------------------------------------------------------------
module ula_seq
    import ula_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   opcode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic [N-1:0] s_hi,
    output logic         c,
    output logic         z,
    output logic         n,
    output logic         v,
    output logic         err
);
    localparam int SW = $clog2(N);

    logic [1:0]    state;
    logic          accept;
    flags_t        flags;
    logic [N-1:0]  res_s;
    flags_t        res_f;
    logic [N:0]    add_w;
    logic [N:0]    sub_w;
    logic [N:0]    shl_w;
    logic [N:0]    shr_w;
    logic [SW-1:0] sh;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign sh       = b[SW-1:0];
    assign {c, z, n, v, err} = flags;

    // Single-cycle operations, evaluated on the raw inputs at the accept edge.
    always_comb begin
        add_w = {1'b0, a} + {1'b0, b};
        sub_w = {1'b0, a} - {1'b0, b};   // bit N is the borrow
        shl_w = {1'b0, a} << sh;         // bit N is the last bit shifted out
        shr_w = {a, 1'b0} >> sh;         // bit 0 is the last bit shifted out
        res_s = '0;
        res_f = '0;
        case (opcode)
            OP_ADD: begin
                res_s   = add_w[N-1:0];
                res_f.c = add_w[N];
                res_f.v = (a[N-1] == b[N-1]) && (add_w[N-1] != a[N-1]);
            end
            OP_SUB: begin
                res_s   = sub_w[N-1:0];
                res_f.c = sub_w[N];
                res_f.v = (a[N-1] != b[N-1]) && (sub_w[N-1] != a[N-1]);
            end
            OP_AND: res_s = a & b;
            OP_OR:  res_s = a | b;
            OP_XOR: res_s = a ^ b;
            OP_NOT: res_s = ~a;
            OP_EQ:  res_s = {{(N-1){1'b0}}, (a == b)};
            OP_NEQ: res_s = {{(N-1){1'b0}}, (a != b)};
            OP_SHL: begin
                res_s   = shl_w[N-1:0];
                res_f.c = shl_w[N];
            end
            OP_SHR: begin
                res_s   = shr_w[N:1];
                res_f.c = shr_w[0];
            end
            // MUL (when built) is handled by the multiplier path; otherwise invalid.
            default: res_f.err = 1'b1;
        endcase
        res_f.n = res_s[N-1];
        res_f.z = (res_s == '0);
    end

`ifdef ULA_SEQ_MUL_EN
    logic           mul_start;
    logic           mul_done;
    logic [2*N-1:0] mul_product;
    logic [N-1:0]   s_hi_q;

    assign mul_start = accept && (opcode == OP_MUL);
    assign s_hi      = s_hi_q;

    ula_seq_mul #(.N(N)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .step    (state == ST_BUSY),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign s_hi = '0;
`endif

    // NOTE: the async reset clears only control and output registers; no memory arrays exist here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            s         <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
`ifdef ULA_SEQ_MUL_EN
            s_hi_q    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
`ifdef ULA_SEQ_MUL_EN
                        if (opcode == OP_MUL) begin
                            state <= ST_BUSY;
                        end else begin
                            state     <= ST_HOLD;
                            s         <= res_s;
                            s_hi_q    <= '0;
                            flags     <= res_f;
                            out_valid <= 1'b1;
                        end
`else
                        state     <= ST_HOLD;
                        s         <= res_s;
                        flags     <= res_f;
                        out_valid <= 1'b1;
`endif
                    end
                end
`ifdef ULA_SEQ_MUL_EN
                ST_BUSY: begin
                    if (mul_done) begin
                        state     <= ST_HOLD;
                        s         <= mul_product[N-1:0];
                        s_hi_q    <= mul_product[2*N-1:N];
                        flags.c   <= (mul_product[2*N-1:N] != '0);
                        flags.z   <= (mul_product == '0);
                        flags.n   <= mul_product[N-1];
                        flags.v   <= 1'b0;
                        flags.err <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
`endif
                ST_HOLD: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// ---------------------------------------------------------------------------
// tb_ula_seq
//   Self-checking bench for ula_seq (N=8). Expected results come from an
//   integer-arithmetic reference model of the operation rules. Works for
//   both builds: ULA_SEQ_MUL_EN defined or undefined.
// ---------------------------------------------------------------------------
module tb_ula_seq;

    localparam int N = 8;

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] s_hi;
        logic c;
        logic z;
        logic n;
        logic v;
        logic err;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [3:0]   opcode = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] s;
    logic [N-1:0] s_hi;
    logic         c, z, n, v, err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ula_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .s_hi      (s_hi),
        .c         (c),
        .z         (z),
        .n         (n),
        .v         (v),
        .err       (err)
    );

    function automatic res_t sample();
        res_t r;
        r = {s, s_hi, c, z, n, v, err};
        return r;
    endfunction

    // Reference model: plain integer arithmetic on the operation rules.
    function automatic res_t model(input int op, input int aa, input int bb);
        res_t r;
        int   sa, sb, t, sh;
        r  = '0;
        sa = (aa >= 128) ? aa - 256 : aa;
        sb = (bb >= 128) ? bb - 256 : bb;
        sh = bb % 8;
        case (op)
            0: begin
                t = aa + bb;   r.s = 8'(t % 256); r.c = (t > 255);
                t = sa + sb;   r.v = (t > 127) || (t < -128);
            end
            1: begin
                t = aa - bb;   r.s = 8'((t + 256) % 256); r.c = (aa < bb);
                t = sa - sb;   r.v = (t > 127) || (t < -128);
            end
            2: r.s = 8'(aa & bb);
            3: r.s = 8'(aa | bb);
            4: r.s = 8'(aa ^ bb);
            5: r.s = 8'(255 - aa);
            6: r.s = (aa == bb) ? 8'd1 : 8'd0;
            7: r.s = (aa != bb) ? 8'd1 : 8'd0;
`ifdef ULA_SEQ_MUL_EN
            8: begin
                t = aa * bb;
                r.s = 8'(t % 256); r.s_hi = 8'(t / 256); r.c = (t >= 256);
            end
`endif
            9: begin
                t = aa * (1 << sh);
                r.s = 8'(t % 256); r.c = (sh != 0) && (((t / 256) % 2) == 1);
            end
            10: begin
                r.s = 8'(aa / (1 << sh));
                r.c = (sh != 0) && (((aa >> (sh - 1)) % 2) == 1);
            end
            default: r.err = 1'b1;
        endcase
        r.n = r.s[7];
        r.z = (r.s == 8'd0) && (r.s_hi == 8'd0);
        return r;
    endfunction

    function automatic int exp_lat(input int op);
`ifdef ULA_SEQ_MUL_EN
        return (op == 8) ? N + 1 : 1;
`else
        return (op == 8) ? 1 : 1;
`endif
    endfunction

    // Drives one operation from IDLE, scrambles inputs after the accept edge,
    // holds out_ready=0 for 'hold' cycles, then releases the result.
    // lat = -1 if no result appeared within the cycle budget.
    task automatic do_op(input logic [3:0] op, input logic [7:0] aa, input logic [7:0] bb,
                         input int hold, output res_t obs, output int lat, output int unstable);
        @(negedge clk);
        in_valid  = 1'b1;
        opcode    = op;
        a         = aa;
        b         = bb;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        a        = 8'($urandom);
        b        = 8'($urandom);
        opcode   = 4'($urandom);
        in_valid = 1'b1;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat <= 40) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
        obs = sample();
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            a = 8'($urandom);
            b = 8'($urandom);
            if (sample() !== obs || in_ready !== 1'b0 || out_valid !== 1'b1) unstable++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({sample(), out_valid} !== {21'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%b required 0/0", sample(), out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [3:0] ops [7] = '{4'd0, 4'd0, 4'd1, 4'd8, 4'd8, 4'd12, 4'd5};
        logic [7:0] as  [7] = '{8'd200, 8'd127, 8'd5, 8'd16, 8'd15, 8'd3, 8'h5A};
        logic [7:0] bs  [7] = '{8'd100, 8'd1, 8'd7, 8'd16, 8'd17, 8'd4, 8'h00};
        res_t obs, exp;
        int   lat, unst;
        for (int i = 0; i < 7; i++) begin
            do_op(ops[i], as[i], bs[i], 0, obs, lat, unst);
            exp = model(int'(ops[i]), int'(as[i]), int'(bs[i]));
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL directed_%0d op%0d: got %h required %h", i, ops[i], obs, exp);
            end
            n_checks++;
            if (lat != exp_lat(int'(ops[i]))) begin
                n_fail++;
                $display("FAIL directed_lat_%0d op%0d: got %0d required %0d", i, ops[i], lat, exp_lat(int'(ops[i])));
            end
            if (i == 0) begin
                n_checks++;
                if (obs !== {8'h2C, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL add_200_100: got %h required 2c00 c=1", obs);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        res_t obs, exp;
        int   lat, unst;
        do_op(4'd4, 8'hF0, 8'h3C, 5, obs, lat, unst);
        exp = model(4, 'hF0, 'h3C);
        n_checks++;
        if (obs !== exp || obs.s !== 8'hCC) begin
            n_fail++;
            $display("FAIL bp_result: got %h required %h", obs, exp);
        end
        n_checks++;
        if (unst != 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d unstable cycles required 0", unst);
        end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    // in_valid held high across the HOLD->IDLE edge must not be accepted on that edge.
    task automatic test_back_to_back();
        @(negedge clk);
        in_valid = 1'b1; opcode = 4'd0; a = 8'd10; b = 8'd20; out_ready = 1'b0;
        @(posedge clk);
        #1;
        a = 8'd1; b = 8'd2;
        @(negedge clk);
        n_checks++;
        if (s !== 8'd30 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got s=%0d ov=%b required 30/1", s, out_valid);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || s !== 8'd30) begin
            n_fail++;
            $display("FAIL b2b_gap: got ov=%b ir=%b s=%0d required 0/1/30", out_valid, in_ready, s);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || s !== 8'd3) begin
            n_fail++;
            $display("FAIL b2b_second: got ov=%b s=%0d required 1/3", out_valid, s);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        res_t obs, exp;
        int   lat, unst, op, aa, bb, hold;
        for (int i = 0; i < 80; i++) begin
            op   = $urandom_range(0, 15);
            aa   = $urandom_range(0, 255);
            bb   = $urandom_range(0, 255);
            hold = $urandom_range(0, 3);
            do_op(4'(op), 8'(aa), 8'(bb), hold, obs, lat, unst);
            exp = model(op, aa, bb);
            n_checks++;
            if (obs !== exp || lat != exp_lat(op) || unst != 0) begin
                n_fail++;
                $display("FAIL random_%0d op%0d a=%0d b=%0d: got %h lat=%0d unst=%0d required %h lat=%0d",
                         i, op, aa, bb, obs, lat, unst, exp, exp_lat(op));
            end
        end
    endtask

    task automatic test_reset_mid_op();
        res_t obs, exp;
        int   lat, unst;
        do_op(4'd0, 8'd200, 8'd100, 0, obs, lat, unst);
        @(negedge clk);
        in_valid = 1'b1; opcode = 4'd8; a = 8'd16; b = 8'd16;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sample(), out_valid} !== {21'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL midop_reset: got %h/%b required 0/0", sample(), out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_release: got ir=%b ov=%b required 1/0", in_ready, out_valid);
        end
        do_op(4'd0, 8'd100, 8'd50, 0, obs, lat, unst);
        exp = model(0, 100, 50);
        n_checks++;
        if (obs !== exp || lat != 1) begin
            n_fail++;
            $display("FAIL midop_next_add: got %h lat=%0d required %h lat=1", obs, lat, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
